message_composer: RTL and testbench
===================================

# message_composer

Line-editing stage between the PS/2 path (keyboard scan-code decoder plus ASCII converter) and the GPIO link transmitter and character LCD. It accepts one ASCII character per key strobe and builds a 16-character message, handling backspace and enter. Enter hands the frozen message to the link through a valid/ready handshake. The live buffer is exported continuously for the LCD.

## Interface
Parameters:
- MAX_CHARS, 16: message capacity in characters; message width is MAX_CHARS*8.
- PAD_CHAR, 8'h20: fill byte for unused character slots.

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- reset  in  1  reset; synchronous, active-high.
- enable  in  1  keys are accepted only while high; the top level drives it high in the sending display state.
- key_valid  in  1  scan-code-ready strobe; may stay high for several cycles.
- key_ascii  in  8  ASCII code; valid while key_valid is high.
- clear  in  1  synchronous buffer wipe.
- display_data  out  128  live edit buffer; character i occupies bits [8i+7:8i], so char 0 is the LSB byte.
- msg_data  out  128  snapshot of the message offered to the link.
- msg_len  out  5  number of characters in msg_data, 1..16.
- msg_valid  out  1  message offered to the link.
- msg_ready  in  1  link accepts the message.
- overflow  out  1  one-cycle pulse when a character is dropped because the buffer is full.

## Operation
- One clock, synchronous active-high reset.
- Reset values:
  - display_data and msg_data are all PAD_CHAR.
  - msg_len = 0, msg_valid = 0, overflow = 0.
  - Internal len = 0, state = EDIT, key_valid_q = 0.
- Key event: key_valid high AND key_valid_q low. Exactly one event is produced per high pulse, whatever its length.
- States:
  - EDIT: accepts events when enable = 1. Events with enable = 0 are discarded, not queued.
  - SEND: msg_valid = 1. All key events and clear are ignored; key_valid_q still tracks key_valid.
- Event decode in EDIT:
  - 0x20..0x7E, len < MAX_CHARS: write the byte into slot len, then len += 1.
  - 0x20..0x7E, len == MAX_CHARS: buffer unchanged; overflow pulses.
  - 0x08 (backspace), len > 0: len -= 1, and the vacated slot is set to PAD_CHAR.
  - 0x08 (backspace), len == 0: ignored.
  - 0x0D (enter), len > 0: msg_data <= buffer, msg_len <= len, go to SEND.
  - 0x0D (enter), len == 0: ignored.
  - Any other code: ignored.
- clear in EDIT: buffer set to all PAD_CHAR, len = 0. clear takes priority over a key event in the same cycle; that event is consumed and dropped.
- SEND exits on msg_valid & msg_ready at a clock edge:
  - msg_valid falls the next cycle.
  - The buffer is cleared and len = 0.
  - State returns to EDIT.
- msg_data and msg_len hold their values after the transfer until the next enter.
- Reset mid-SEND: msg_valid drops the next cycle with no transfer; all state returns to reset values.

## Timing
- Edge N samples a key event: display_data reflects it after edge N, visible in cycle N+1.
- Enter sampled at edge N: msg_valid = 1 in cycle N+1.
- msg_valid must not fall before the handshake completes; msg_data and msg_len are stable while msg_valid = 1.
- msg_ready high in the same cycle msg_valid rises: the transfer happens at the next edge, so msg_valid is high for exactly one cycle.
- A key event arriving on the exact edge of the transfer is dropped, because the state is still SEND at that edge.
- overflow is high for exactly one cycle per dropped character.
- No combinational path from any input to any output: every output comes from a register.

## Structure
- Shared package, msg_pkg, holds:
  - KEY_BS = 8'h08, KEY_ENTER = 8'h0D, ASCII_MIN = 8'h20, ASCII_MAX = 8'h7E;
  - PAD_CHAR default;
  - state encoding EDIT = 1'b0, SEND = 1'b1;
  - MSG_W = 128.
- Sub-module rise_detect(clock, reset, in, pulse) produces the key event; it is reusable for other strobes at the top level.
- The buffer is a single 128-bit register with a byte-slot write decoded from len.

## Test plan
- Reset, then keys 'H'(0x48), 'i'(0x69), then enter with msg_ready = 1 → display_data[15:0] = 16'h6948 after 2 events; msg_valid is high for 1 cycle with msg_data = {14×8'h20, 8'h69, 8'h48} and msg_len = 2; display_data then returns to all 0x20.
- key_valid held high 10 cycles with 'a' → exactly one 0x61 written and len = 1; enter with len = 0 → msg_valid stays 0.
- 17 printable keys → bytes 0..15 filled and msg_len = 16 on enter; the 17th key gives an overflow pulse of exactly 1 cycle and the buffer is unchanged.
- 'a','b', backspace, backspace, backspace → slots 0 and 1 are 0x20 and len = 0; the third backspace is ignored with no underflow.
- Enter with msg_ready = 0 for 5 cycles while 'x' is typed and clear is pulsed → msg_valid and msg_data are stable, 'x' and clear are ignored; msg_ready = 1 → one transfer, then EDIT.
- Reset asserted while msg_valid = 1 → msg_valid = 0 and all outputs return to reset values the next cycle; enable = 0 during a key → event dropped.

Source files
------------

// File: rtl/msg_pkg.sv
// Shared constants and state encoding for the message composer line editor.
package msg_pkg;

   localparam logic [7:0] KEY_BS           = 8'h08;
   localparam logic [7:0] KEY_ENTER        = 8'h0D;
   localparam logic [7:0] ASCII_MIN        = 8'h20;
   localparam logic [7:0] ASCII_MAX        = 8'h7E;
   localparam logic [7:0] PAD_CHAR_DEFAULT = 8'h20;
   localparam int unsigned MSG_W           = 128;

   typedef enum logic {
      EDIT = 1'b0,
      SEND = 1'b1
   } state_e;

   function automatic logic is_printable(input logic [7:0] code);
      return (code >= ASCII_MIN) && (code <= ASCII_MAX);
   endfunction

endpackage

// File: rtl/message_composer_rise_detect.sv
// Rising-edge detector: one pulse per low-to-high transition of a level strobe.
module rise_detect (
   input  logic clock,
   input  logic reset,
   input  logic in,
   output logic pulse
);

   logic in_q;

   always_ff @(posedge clock) begin
      if (reset) in_q <= 1'b0;
      else       in_q <= in;
   end

   assign pulse = in & ~in_q;

endmodule

// File: rtl/message_composer.sv
// Line editor: builds a message from key strobes, hands it to the link on enter.
module message_composer
   import msg_pkg::*;
#(
   parameter int unsigned MAX_CHARS = 16,
   parameter logic [7:0]  PAD_CHAR  = PAD_CHAR_DEFAULT
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               enable,
   input  logic                               key_valid,
   input  logic [7:0]                         key_ascii,
   input  logic                               clear,
   output logic [MAX_CHARS*8-1:0]             display_data,
   output logic [MAX_CHARS*8-1:0]             msg_data,
   output logic [$clog2(MAX_CHARS+1)-1:0]     msg_len,
   output logic                               msg_valid,
   input  logic                               msg_ready,
   output logic                               overflow
);

   localparam int unsigned BUF_W = MAX_CHARS * 8;
   localparam int unsigned LEN_W = $clog2(MAX_CHARS + 1);
   localparam logic [BUF_W-1:0] PAD_FILL = {MAX_CHARS{PAD_CHAR}};

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [BUF_W-1:0]   msg_data_q, msg_data_d;
   logic [LEN_W-1:0]   msg_len_q, msg_len_d;
   logic               msg_valid_q, msg_valid_d;
   logic               overflow_q, overflow_d;
   logic               key_evt;

   rise_detect u_key_rise (
      .clock (clock),
      .reset (reset),
      .in    (key_valid),
      .pulse (key_evt)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= EDIT;
         len_q       <= '0;
         buf_q       <= PAD_FILL;
         msg_data_q  <= PAD_FILL;
         msg_len_q   <= '0;
         msg_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         buf_q       <= buf_d;
         msg_data_q  <= msg_data_d;
         msg_len_q   <= msg_len_d;
         msg_valid_q <= msg_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   // Edit/send control; key events and clear only act while editing.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      buf_d      = buf_q;
      msg_data_d = msg_data_q;
      msg_len_d  = msg_len_q;
      overflow_d = 1'b0;

      unique case (state_q)
         EDIT: begin
            if (clear) begin
               buf_d = PAD_FILL;
               len_d = '0;
            end else if (enable && key_evt) begin
               if (is_printable(key_ascii)) begin
                  if (len_q < LEN_W'(MAX_CHARS)) begin
                     for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                        if (LEN_W'(i) == len_q) buf_d[i*8 +: 8] = key_ascii;
                     end
                     len_d = len_q + LEN_W'(1);
                  end else begin
                     overflow_d = 1'b1;
                  end
               end else if (key_ascii == KEY_BS && len_q != '0) begin
                  for (int unsigned i = 0; i < MAX_CHARS; i++) begin
                     if (LEN_W'(i) == len_q - LEN_W'(1)) buf_d[i*8 +: 8] = PAD_CHAR;
                  end
                  len_d = len_q - LEN_W'(1);
               end else if (key_ascii == KEY_ENTER && len_q != '0) begin
                  msg_data_d = buf_q;
                  msg_len_d  = len_q;
                  state_d    = SEND;
               end
            end
         end
         SEND: begin
            if (msg_ready) begin
               buf_d   = PAD_FILL;
               len_d   = '0;
               state_d = EDIT;
            end
         end
         default: state_d = EDIT;
      endcase

      msg_valid_d = (state_d == SEND);
   end

   assign display_data = buf_q;
   assign msg_data     = msg_data_q;
   assign msg_len      = msg_len_q;
   assign msg_valid    = msg_valid_q;
   assign overflow     = overflow_q;

endmodule

// File: tb/tb_message_composer.sv
// Directed self-checking bench for message_composer.
module tb_message_composer;

   localparam logic [127:0] PAD = {16{8'h20}};

   logic         clock = 1'b0;
   logic         reset, enable, key_valid, clear, msg_ready;
   logic [7:0]   key_ascii;
   logic [127:0] display_data, msg_data;
   logic [4:0]   msg_len;
   logic         msg_valid, overflow;

   int checks = 0;
   int errors = 0;

   message_composer dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .key_valid    (key_valid),
      .key_ascii    (key_ascii),
      .clear        (clear),
      .display_data (display_data),
      .msg_data     (msg_data),
      .msg_len      (msg_len),
      .msg_valid    (msg_valid),
      .msg_ready    (msg_ready),
      .overflow     (overflow)
   );

   always #5 clock = ~clock;

   // One-cycle key strobe; returns at the negedge after the sampling edge.
   task automatic press(input logic [7:0] ch);
      @(negedge clock);
      key_valid = 1'b1;
      key_ascii = ch;
      @(negedge clock);
      key_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      @(negedge clock);
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; key_valid = 1'b0; key_ascii = 8'h00;
      clear = 1'b0; msg_ready = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      checks++;
      if (display_data !== PAD || msg_data !== PAD || msg_len !== 5'd0 ||
          msg_valid !== 1'b0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset: disp=%h data=%h len=%0d valid=%b ovf=%b",
                  display_data, msg_data, msg_len, msg_valid, overflow);
      end
   endtask

   task automatic test_basic();
      logic [127:0] exp;
      msg_ready = 1'b1;
      press(8'h48);
      press(8'h69);
      checks++;
      if (display_data[15:0] !== 16'h6948) begin
         errors++;
         $display("FAIL basic_disp: got %h want 6948", display_data[15:0]);
      end
      press(8'h0D);
      exp = PAD;
      exp[15:0] = 16'h6948;
      checks++;
      if (msg_valid !== 1'b1 || msg_data !== exp || msg_len !== 5'd2) begin
         errors++;
         $display("FAIL basic_send: valid=%b data=%h len=%0d want 1 %h 2",
                  msg_valid, msg_data, msg_len, exp);
      end
      @(negedge clock);
      checks++;
      if (msg_valid !== 1'b0 || display_data !== PAD || msg_data !== exp || msg_len !== 5'd2) begin
         errors++;
         $display("FAIL basic_after: valid=%b disp=%h data=%h len=%0d",
                  msg_valid, display_data, msg_data, msg_len);
      end
   endtask

   task automatic test_held_key();
      @(negedge clock);
      key_valid = 1'b1;
      key_ascii = 8'h61;
      repeat (10) @(negedge clock);
      key_valid = 1'b0;
      press(8'h62);
      checks++;
      if (display_data[23:0] !== 24'h2062_61 || display_data[127:24] !== PAD[127:24]) begin
         errors++;
         $display("FAIL held_key: got %h want low bytes 206261", display_data);
      end
      pulse_clear();
      press(8'h0D);
      repeat (2) begin
         checks++;
         if (msg_valid !== 1'b0 || display_data !== PAD) begin
            errors++;
            $display("FAIL empty_enter: valid=%b disp=%h want 0 pad", msg_valid, display_data);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_full();
      logic [127:0] exp;
      msg_ready = 1'b0;
      exp = PAD;
      for (int i = 0; i < 16; i++) begin
         press(8'(8'h41 + i));
         exp[i*8 +: 8] = 8'(8'h41 + i);
      end
      checks++;
      if (display_data !== exp) begin
         errors++;
         $display("FAIL full_disp: got %h want %h", display_data, exp);
      end
      press(8'h5A);
      checks++;
      if (overflow !== 1'b1 || display_data !== exp) begin
         errors++;
         $display("FAIL overflow_pulse: ovf=%b disp=%h want 1 %h", overflow, display_data, exp);
      end
      @(negedge clock);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_width: ovf=%b want 0", overflow);
      end
      press(8'h0D);
      checks++;
      if (msg_valid !== 1'b1 || msg_len !== 5'd16 || msg_data !== exp) begin
         errors++;
         $display("FAIL full_send: valid=%b len=%0d data=%h", msg_valid, msg_len, msg_data);
      end
      msg_ready = 1'b1;
      @(negedge clock);
      msg_ready = 1'b0;
      checks++;
      if (msg_valid !== 1'b0 || display_data !== PAD) begin
         errors++;
         $display("FAIL full_xfer: valid=%b disp=%h", msg_valid, display_data);
      end
   endtask

   task automatic test_backspace();
      logic [127:0] exp;
      press(8'h61);
      press(8'h62);
      press(8'h08);
      exp = PAD;
      exp[7:0] = 8'h61;
      checks++;
      if (display_data !== exp) begin
         errors++;
         $display("FAIL bs_one: got %h want %h", display_data, exp);
      end
      press(8'h08);
      press(8'h08);
      checks++;
      if (display_data !== PAD) begin
         errors++;
         $display("FAIL bs_empty: got %h want pad", display_data);
      end
      press(8'h63);
      exp[7:0] = 8'h63;
      checks++;
      if (display_data !== exp) begin
         errors++;
         $display("FAIL bs_underflow: got %h want %h", display_data, exp);
      end
      pulse_clear();
   endtask

   task automatic test_back_to_back();
      logic [127:0] exp;
      msg_ready = 1'b0;
      exp = PAD;
      exp[7:0] = 8'h71;
      press(8'h71);
      press(8'h0D);
      press(8'h78);
      pulse_clear();
      @(negedge clock);
      checks++;
      if (msg_valid !== 1'b1 || msg_data !== exp || msg_len !== 5'd1 || display_data !== exp) begin
         errors++;
         $display("FAIL stall: valid=%b data=%h len=%0d disp=%h",
                  msg_valid, msg_data, msg_len, display_data);
      end
      msg_ready = 1'b1;
      @(negedge clock);
      msg_ready = 1'b0;
      checks++;
      if (msg_valid !== 1'b0 || display_data !== PAD || msg_data !== exp) begin
         errors++;
         $display("FAIL stall_xfer: valid=%b disp=%h data=%h", msg_valid, display_data, msg_data);
      end
      press(8'h79);
      checks++;
      if (display_data[15:0] !== 16'h2079 || msg_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_edit: disp=%h valid=%b", display_data[15:0], msg_valid);
      end
      pulse_clear();
   endtask

   task automatic test_reset_send();
      msg_ready = 1'b0;
      press(8'h72);
      press(8'h0D);
      checks++;
      if (msg_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre: valid=%b want 1", msg_valid);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if (msg_valid !== 1'b0 || msg_data !== PAD || msg_len !== 5'd0 || display_data !== PAD) begin
         errors++;
         $display("FAIL rst_send: valid=%b data=%h len=%0d disp=%h",
                  msg_valid, msg_data, msg_len, display_data);
      end
      enable = 1'b0;
      press(8'h6B);
      enable = 1'b1;
      @(negedge clock);
      checks++;
      if (display_data !== PAD) begin
         errors++;
         $display("FAIL enable_low: got %h want pad", display_data);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_held_key();
      test_full();
      test_backspace();
      test_back_to_back();
      test_reset_send();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
